// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory request/response, redirect input and
// the decode-side instruction stream.
interface fetch_unit_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        mem_resp_err;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    logic        out_fault;

    // Fetch unit side.
    modport master (
        output mem_req_valid, mem_req_addr, out_valid, out_inst, out_pc, out_fault,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
        input  redirect_valid, redirect_pc, out_ready
    );

    // Memory / pipeline side.
    modport slave (
        input  mem_req_valid, mem_req_addr, out_valid, out_inst, out_pc, out_fault,
        output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
        output redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request at a time, a circular
// instruction buffer towards decode, and redirect handling that drains a request
// already accepted by memory before fetching from the new address.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StDrain, StFault} state_e;

    state_e        state_q, state_d;
    logic [63:0]   fetch_pc_q, fetch_pc_d;
    logic [63:0]   inflight_pc_q, inflight_pc_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];
    logic [63:0]   pc_q [DEPTH];
    logic [63:0]   pc_d [DEPTH];
    logic          err_q [DEPTH];
    logic          err_d [DEPTH];
    logic          push, pop;

    // Next-state: FSM, fetch PC, buffer push/pop; redirect overrides everything.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        count_d       = count_q;
        data_d        = data_q;
        pc_d          = pc_q;
        err_d         = err_q;
        push          = 1'b0;
        pop           = (count_q != '0) && bus.out_ready;

        case (state_q)
            // Nothing is outstanding here, so occupancy is just the buffer count.
            StIdle: if (count_q < DepthCnt) state_d = StReq;
            StReq: begin
                if (bus.mem_req_ready) begin
                    state_d       = StWait;
                    inflight_pc_d = fetch_pc_q;
                    fetch_pc_d    = fetch_pc_q + 64'd4;
                end
            end
            StWait: begin
                if (bus.mem_resp_valid) begin
                    push    = 1'b1;
                    state_d = bus.mem_resp_err ? StFault : StIdle;
                end
            end
            StDrain: if (bus.mem_resp_valid) state_d = StIdle;
            StFault: state_d = StFault;
            default: state_d = StIdle;
        endcase

        if (push) begin
            data_d[wptr_q] = bus.mem_resp_data;
            pc_d[wptr_q]   = inflight_pc_q;
            err_d[wptr_q]  = bus.mem_resp_err;
            wptr_d         = wptr_q + AW'(1);
        end
        if (pop) rptr_d = rptr_q + AW'(1);
        if (push && !pop) count_d = count_q + (AW + 1)'(1);
        else if (!push && pop) count_d = count_q - (AW + 1)'(1);

        if (bus.redirect_valid) begin
            fetch_pc_d = {bus.redirect_pc[63:2], 2'b00};
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            // A request memory has accepted still owes a response; swallow it in drain.
            if ((state_q == StWait && !bus.mem_resp_valid) ||
                (state_q == StReq && bus.mem_req_ready) ||
                (state_q == StDrain && !bus.mem_resp_valid)) begin
                state_d = StDrain;
            end else begin
                state_d = StIdle;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
                err_q[i]  <= 1'b0;
            end
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            count_q       <= count_d;
            data_q        <= data_d;
            pc_q          <= pc_d;
            err_q         <= err_d;
        end
    end

    // Outputs decode registered state only; no path from mem_resp_* to out_*.
    assign bus.mem_req_valid = (state_q == StReq);
    assign bus.mem_req_addr  = (state_q == StReq) ? fetch_pc_q : '0;
    assign bus.out_valid     = (count_q != '0);
    assign bus.out_inst      = bus.out_valid ? data_q[rptr_q] : '0;
    assign bus.out_pc        = bus.out_valid ? pc_q[rptr_q] : '0;
    assign bus.out_fault     = bus.out_valid ? err_q[rptr_q] : 1'b0;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model with programmable response delay,
// scoreboard of expected instructions filled as responses are driven.
module tb_fetch_unit;
    localparam logic [63:0] ResetPc = 64'h8000_0000;
    localparam int unsigned Depth   = 2;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    logic clk;
    logic rst;
    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(ResetPc), .DEPTH(Depth)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        sb[$];
    logic [63:0] pop_log[$];
    logic [63:0] req_log[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          epoch    = 0;
    bit          pend_active = 0;
    int          pend_wait   = 0;
    int          pend_epoch  = 0;
    logic [63:0] pend_addr   = '0;
    int          resp_delay  = 1;
    logic [63:0] err_addr    = '1;
    bit          saw_fault   = 0;

    function automatic logic [31:0] mem_data(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9bdf;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive memory response at negedge, score pops, log requests.
    task automatic step();
        exp_t e;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        bus.mem_resp_err   = 1'b0;
        if (pend_active) begin
            if (pend_wait == 0) begin
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_data  = mem_data(pend_addr);
                bus.mem_resp_err   = (pend_addr == err_addr);
                if (pend_epoch == epoch && !bus.redirect_valid) begin
                    e.pc    = pend_addr;
                    e.inst  = mem_data(pend_addr);
                    e.fault = (pend_addr == err_addr);
                    sb.push_back(e);
                end
                pend_active = 0;
            end else begin
                pend_wait--;
            end
        end
        if (bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_pc", bus.out_pc, e.pc);
                chk("out_inst", 64'(bus.out_inst), 64'(e.inst));
                chk("out_fault", 64'(bus.out_fault), 64'(e.fault));
                pop_log.push_back(bus.out_pc);
                if (bus.out_fault) saw_fault = 1;
            end
        end
        if (bus.redirect_valid) sb.delete();
        if (bus.mem_req_valid && bus.mem_req_ready) begin
            chk("one_outstanding", 64'(pend_active), 64'd0);
            pend_active = 1;
            pend_addr   = bus.mem_req_addr;
            pend_epoch  = epoch;
            pend_wait   = resp_delay - 1;
            req_log.push_back(bus.mem_req_addr);
        end
        if (bus.redirect_valid) epoch++;
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [63:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        step();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
    endtask

    initial begin
        logic [63:0] a0;
        logic [63:0] snap_pc;
        logic [31:0] snap_inst;
        int          snap_req;
        bit          hit;

        rst                = 1'b0;
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        bus.mem_resp_err   = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
        chk("rst_req_addr", bus.mem_req_addr, 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_inst", 64'(bus.out_inst), 64'd0);
        chk("rst_out_pc", bus.out_pc, 64'd0);
        chk("rst_out_fault", 64'(bus.out_fault), 64'd0);

        // Release: IDLE first, request at RESET_PC the following cycle.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel_idle", 64'(bus.mem_req_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("rel_req_valid", 64'(bus.mem_req_valid), 64'd1);
        chk("rel_req_addr", bus.mem_req_addr, ResetPc);

        // Streaming with ready memory and ready decode.
        bus.out_ready = 1'b1;
        pop_log.delete();
        repeat (14) step();
        chk("seq_len_ge3", 64'(pop_log.size() >= 3), 64'd1);
        if (pop_log.size() >= 3) begin
            chk("seq0", pop_log[0], 64'h8000_0000);
            chk("seq1", pop_log[1], 64'h8000_0004);
            chk("seq2", pop_log[2], 64'h8000_0008);
        end

        // Backpressure: buffer fills to DEPTH, requests stop, head holds.
        bus.out_ready = 1'b0;
        repeat (7) step();
        snap_pc   = bus.out_pc;
        snap_inst = bus.out_inst;
        repeat (3) step();
        chk("bp_req_stop", 64'(bus.mem_req_valid), 64'd0);
        chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_entries", 64'(sb.size()), 64'(Depth));
        chk("bp_hold_pc", bus.out_pc, snap_pc);
        chk("bp_hold_inst", 64'(bus.out_inst), 64'(snap_inst));
        bus.out_ready = 1'b1;
        repeat (12) step();

        // Redirect while WAIT with response one cycle later: response dropped.
        resp_delay = 2;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            hit = pend_active && (pend_wait == 1);
        end
        chk("wait_reached", 64'(hit), 64'd1);
        redirect_to(64'h8000_1002);
        chk("drain_no_req", 64'(bus.mem_req_valid), 64'd0);
        chk("drain_empty", 64'(bus.out_valid), 64'd0);
        step();
        chk("drop_empty", 64'(bus.out_valid), 64'd0);
        req_log.delete();
        repeat (6) step();
        chk("redir_req_seen", 64'(req_log.size() != 0), 64'd1);
        if (req_log.size() != 0) chk("redir_addr", req_log[0], 64'h8000_1000);
        repeat (8) step();

        // Access fault at 0x80000008: delivered with fault, fetch stops until redirect.
        resp_delay = 1;
        err_addr   = 64'h8000_0008;
        saw_fault  = 0;
        redirect_to(64'h8000_0000);
        repeat (20) step();
        chk("fault_seen", 64'(saw_fault), 64'd1);
        chk("fault_no_req", 64'(bus.mem_req_valid), 64'd0);
        chk("fault_last_req", req_log[$], 64'h8000_0008);
        snap_req = req_log.size();
        repeat (5) step();
        chk("fault_quiet", 64'(req_log.size()), 64'(snap_req));
        err_addr = '1;
        req_log.delete();
        redirect_to(64'h8000_0100);
        repeat (4) step();
        chk("fault_resume_seen", 64'(req_log.size() != 0), 64'd1);
        if (req_log.size() != 0) chk("fault_resume_addr", req_log[0], 64'h8000_0100);
        repeat (6) step();

        // Memory stall: address held, redirect withdraws the request.
        bus.mem_req_ready = 1'b0;
        hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            step();
            hit = bus.mem_req_valid;
        end
        chk("stall_req_seen", 64'(hit), 64'd1);
        a0 = bus.mem_req_addr;
        step();
        chk("stall_hold1", bus.mem_req_addr, a0);
        step();
        chk("stall_hold2", bus.mem_req_addr, a0);
        redirect_to(64'h8000_2000);
        chk("stall_withdrawn", 64'(bus.mem_req_valid), 64'd0);
        step();
        chk("stall_new_valid", 64'(bus.mem_req_valid), 64'd1);
        chk("stall_new_addr", bus.mem_req_addr, 64'h8000_2000);
        bus.mem_req_ready = 1'b1;
        repeat (10) step();

        // Asynchronous reset mid-WAIT with one entry buffered.
        bus.out_ready = 1'b0;
        resp_delay    = 2;
        redirect_to(64'h8000_3000);
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            hit = pend_active && (sb.size() == 1);
        end
        chk("arst_setup", 64'(hit), 64'd1);
        chk("arst_pre_valid", 64'(bus.out_valid), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_out_pc", bus.out_pc, 64'd0);
        chk("arst_out_inst", 64'(bus.out_inst), 64'd0);
        chk("arst_req_valid", 64'(bus.mem_req_valid), 64'd0);
        sb.delete();
        pend_active = 0;
        epoch++;
        req_log.delete();
        pop_log.delete();
        bus.mem_resp_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst           = 1'b1;
        resp_delay    = 1;
        bus.out_ready = 1'b1;
        repeat (10) step();
        chk("arst_restart_seen", 64'(req_log.size() != 0), 64'd1);
        if (req_log.size() != 0) chk("arst_restart_addr", req_log[0], ResetPc);
        chk("arst_pop_seen", 64'(pop_log.size() != 0), 64'd1);
        if (pop_log.size() != 0) chk("arst_first_pop", pop_log[0], ResetPc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
